rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
Owns the single write port of the 32x32 register file. It arbitrates between two result producers, the ALU path and the load/store unit return path, and drives write_en, write_addr and write_data as registered outputs. It also keeps a pending-write scoreboard (busy_vec) that issue logic uses for RAW hazard stalls. It sits between the execute/memory stages and reg_file.

Parameters:
XLEN, 32, data width of the write port and the producer data buses
STARVE_LIMIT, 4, number of consecutive lost ALU arbitrations before the ALU gets priority; legal range 1..15
SB_IDX_W, 5, register index width (32 architectural registers)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
issue_valid  in  1  an instruction with a destination register issues this cycle
issue_rd  in  5  destination index of the issuing instruction
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle (combinational)
alu_rd  in  5  ALU destination index
alu_data  in  XLEN  ALU result
lsu_valid  in  1  load result available
lsu_ready  out  1  load result accepted this cycle (combinational)
lsu_rd  in  5  load destination index
lsu_data  in  XLEN  load result
write_en  out  1  to reg_file write_en (registered)
write_addr  out  5  to reg_file write_addr (registered)
write_data  out  XLEN  to reg_file write_data (registered)
busy_vec  out  32  bit i=1 means a write to xi is pending; bit 0 is always 0
idle  out  1  busy_vec==0 and write_en==0

Behaviour:
- Reset (asynchronous, active-low): write_en=0, write_addr=0, write_data=0, busy_vec=0, starve_cnt=0, alu_prio=0. idle=1. In-flight producer transactions are dropped.
- Handshake: a transfer occurs on a rising edge where valid&&ready. Producers hold rd/data stable while valid&&!ready.
- Priority: alu_prio=0 means LSU wins; alu_prio=1 means ALU wins.
  - lsu_ready = !alu_valid || !alu_prio
  - alu_ready = !lsu_valid || alu_prio
  - The ready signals do not depend on their own valid. Both ready signals are high when neither producer is valid.
- Starvation counter:
  - Increments when alu_valid&&lsu_valid&&!alu_prio.
  - Clears on any ALU transfer.
  - alu_prio becomes 1 at the edge where starve_cnt reaches STARVE_LIMIT, and returns to 0 on the ALU transfer.
  - The counter saturates at STARVE_LIMIT.
- Latency: a transfer at edge N sets write_en=1 with the winner's rd/data during cycle N..N+1. reg_file commits at edge N+1. Without a new transfer, write_en returns to 0 at edge N+1.
- rd==0: the transfer is accepted (ready behaves normally), but write_en is 0 for that slot. The scoreboard is untouched.
- Throughput: one write per cycle, with back-to-back transfers allowed.
- Scoreboard:
  - Set: busy_vec[issue_rd] is set at the edge where issue_valid && issue_rd!=0.
  - Clear: busy_vec[write_addr] is cleared at the edge where write_en==1, i.e. the register-file commit edge. A consumer therefore sees busy=0 only when reg_file already holds the value.
  - Simultaneous set and clear of the same index: set wins, because a new producer targets the register.
  - Bit 0 is never set.
- A write to a register whose busy bit is 0 (unscoreboarded write) is legal. The write is performed and the clear is a no-op.
- idle is combinational from the registered state.

Decomposition:
- Shared package rv_core_pkg holds:
  - XLEN and REG_IDX_W constants
  - REG_ZERO = 5'd0
  - wb_src_e enum {WB_SRC_ALU, WB_SRC_LSU}, used internally and in assertions
- One natural sub-module, rf_scoreboard, containing the busy_vec flops plus the set/clear logic. Its inputs are set_en/set_idx/clr_en/clr_idx and its output is busy_vec.
- Arbitration, the starvation counter and the output registers stay in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-stream with busy_vec=32'h0000_0006 and write_en=1 -> outputs go 0 immediately (asynchronous), idle=1; after release, the first ALU transfer (rd=3, data=32'hDEAD_BEEF) gives write_en=1, write_addr=3 the next cycle.
- Contention: alu_valid and lsu_valid held high together, LSU rd=5 data=1,2,3,4,..., ALU rd=7 data=32'hAA -> LSU wins 4 consecutive cycles, then ALU wins the 5th (write_addr=7, write_data=32'hAA), then LSU resumes.
- Scoreboard timing: issue_rd=9 at edge 0; ALU transfer rd=9 at edge 3 -> busy_vec[9]=1 from edge 0 through edge 4 and clears at edge 4, coinciding with write_en=1 during cycle 3..4.
- Set/clear collision: write_en=1 with write_addr=12 while issue_valid=1, issue_rd=12 at the same edge -> busy_vec[12] stays 1.
- x0: LSU transfer with rd=0, data=32'hFFFF_FFFF, plus issue_rd=0 -> lsu_ready=1, write_en stays 0, busy_vec[0]=0, idle stays 1.
- Back-to-back: ALU-only transfers rd=1,2,3 on consecutive edges -> write_en high for 3 consecutive cycles with write_addr 1,2,3, then low.

Source files
------------

// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared core constants and writeback source type
package rv_core_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    WB_SRC_ALU,
    WB_SRC_LSU
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write busy bits for RAW hazard detection
module rf_scoreboard #(
  parameter int IDX_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_en,
  input  logic [IDX_W-1:0]        set_idx,
  input  logic                    clr_en,
  input  logic [IDX_W-1:0]        clr_idx,
  output logic [(1<<IDX_W)-1:0]   busy_vec
);

  localparam int NREG = 1 << IDX_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear: a new producer claiming the register outranks the commit.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - ALU/LSU arbitration onto the single register-file write port
module rf_writeback_arbiter
  import rv_core_pkg::REG_ZERO;
  import rv_core_pkg::wb_src_e;
  import rv_core_pkg::WB_SRC_ALU;
  import rv_core_pkg::WB_SRC_LSU;
#(
  parameter int XLEN         = rv_core_pkg::XLEN,
  parameter int STARVE_LIMIT = 4,
  parameter int SB_IDX_W     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [SB_IDX_W-1:0]        issue_rd,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [SB_IDX_W-1:0]        alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [SB_IDX_W-1:0]        lsu_rd,
  input  logic [XLEN-1:0]            lsu_data,
  output logic                       write_en,
  output logic [SB_IDX_W-1:0]        write_addr,
  output logic [XLEN-1:0]            write_data,
  output logic [(1<<SB_IDX_W)-1:0]   busy_vec,
  output logic                       idle
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                alu_prio_q, alu_prio_d;
  logic                write_en_q, write_en_d;
  logic [SB_IDX_W-1:0] write_addr_q, write_addr_d;
  logic [XLEN-1:0]     write_data_q, write_data_d;

  logic                alu_xfer, lsu_xfer, win_xfer;
  wb_src_e             win_src;
  logic [SB_IDX_W-1:0] win_rd;
  logic [XLEN-1:0]     win_data;

  assign alu_ready = !lsu_valid || alu_prio_q;
  assign lsu_ready = !alu_valid || !alu_prio_q;
  assign alu_xfer  = alu_valid && alu_ready;
  assign lsu_xfer  = lsu_valid && lsu_ready;

  always_comb begin
    win_src  = alu_xfer ? WB_SRC_ALU : WB_SRC_LSU;
    win_xfer = alu_xfer || lsu_xfer;
    win_rd   = (win_src == WB_SRC_ALU) ? alu_rd : lsu_rd;
    win_data = (win_src == WB_SRC_ALU) ? alu_data : lsu_data;

    starve_cnt_d = starve_cnt_q;
    if (alu_xfer) begin
      starve_cnt_d = '0;
    end else if (alu_valid && lsu_valid && !alu_prio_q && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    // Priority flips on the edge the count lands on the limit and holds until the ALU gets through.
    alu_prio_d = alu_xfer ? 1'b0 : (alu_prio_q || starve_cnt_d == LIMIT);

    // x0 transfers are consumed but never reach the register file.
    write_en_d   = win_xfer && (win_rd != REG_ZERO);
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (write_en_d) begin
      write_addr_d = win_rd;
      write_data_d = win_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      alu_prio_q   <= 1'b0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      alu_prio_q   <= alu_prio_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  rf_scoreboard #(
    .IDX_W (SB_IDX_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_valid && issue_rd != REG_ZERO),
    .set_idx  (issue_rd),
    .clr_en   (write_en_q),
    .clr_idx  (write_addr_q),
    .busy_vec (busy_vec)
  );

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign idle       = (busy_vec == '0) && !write_en_q;

  a_single_winner: assert property (@(posedge clk) disable iff (!rst_n) !(alu_xfer && lsu_xfer));
  a_cnt_bounded:   assert property (@(posedge clk) disable iff (!rst_n) starve_cnt_q <= LIMIT);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - randomized and directed checks of rf_writeback_arbiter
module tb_rf_writeback_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] busy_vec;
  logic        idle;

  int vectors     = 0;
  int miscompares = 0;

  rf_writeback_arbiter #(
    .XLEN         (32),
    .STARVE_LIMIT (LIMIT),
    .SB_IDX_W     (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .busy_vec    (busy_vec),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %0b expected 0", write_en); end
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %0b expected 1", idle); end
    @(negedge clk); rst_n = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd1;
    @(negedge clk); issue_rd = 5'd2;
    @(negedge clk); issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    @(negedge clk); alu_valid = 1'b0;
    vectors++; if (busy_vec !== 32'h6) begin miscompares++; $display("FAIL pre_reset_busy: got %h expected 6", busy_vec); end
    vectors++; if (write_en !== 1'b1) begin miscompares++; $display("FAIL pre_reset_we: got %0b expected 1", write_en); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL async_we: got %0b expected 0", write_en); end
    vectors++; if (write_addr !== 5'd0 || write_data !== 32'h0) begin miscompares++; $display("FAIL async_addr_data: got %0d/%h expected 0/0", write_addr, write_data); end
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("FAIL async_busy: got %h expected 0", busy_vec); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL async_idle: got %0b expected 1", idle); end
    @(negedge clk); rst_n = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
    #1;
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %0b expected 1", alu_ready); end
    @(negedge clk); alu_valid = 1'b0;
    vectors++; if (write_en !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL post_reset_write: got en=%0b addr=%0d data=%h expected 1/3/deadbeef", write_en, write_addr, write_data);
    end
    @(negedge clk);
    vectors++; if (write_en !== 1'b0 || idle !== 1'b1) begin miscompares++; $display("FAIL post_reset_drain: got en=%0b idle=%0b expected 0/1", write_en, idle); end
  endtask

  task automatic test_contention();
    int  lsu_n = 1;
    bit  exp_alu;
    clear_inputs();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hAA;
    lsu_valid = 1'b1; lsu_rd = 5'd5;
    for (int i = 0; i < 7; i++) begin
      lsu_data = 32'(lsu_n);
      exp_alu  = (i == LIMIT);
      #1;
      vectors++; if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
        miscompares++; $display("FAIL contention_ready[%0d]: got alu=%0b lsu=%0b expected alu=%0b", i, alu_ready, lsu_ready, exp_alu);
      end
      @(negedge clk);
      vectors++; if (write_en !== 1'b1 || write_addr !== (exp_alu ? 5'd7 : 5'd5) || write_data !== (exp_alu ? 32'hAA : 32'(lsu_n))) begin
        miscompares++; $display("FAIL contention_write[%0d]: got en=%0b addr=%0d data=%h", i, write_en, write_addr, write_data);
      end
      if (!exp_alu) lsu_n++;
    end
    clear_inputs();
    @(negedge clk);
    vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL contention_drain: got %0b expected 0", write_en); end
  endtask

  task automatic test_scoreboard_timing();
    clear_inputs();
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk); issue_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      vectors++; if (busy_vec[9] !== 1'b1) begin miscompares++; $display("FAIL sb_busy_edge%0d: got %0b expected 1", e, busy_vec[9]); end
      if (e == 2) begin alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; end
      else @(negedge clk);
    end
    @(negedge clk); alu_valid = 1'b0;
    vectors++; if (busy_vec[9] !== 1'b1 || write_en !== 1'b1 || write_addr !== 5'd9) begin
      miscompares++; $display("FAIL sb_edge3: got busy=%0b en=%0b addr=%0d expected 1/1/9", busy_vec[9], write_en, write_addr);
    end
    @(negedge clk);
    vectors++; if (busy_vec[9] !== 1'b0 || write_en !== 1'b0) begin
      miscompares++; $display("FAIL sb_edge4: got busy=%0b en=%0b expected 0/0", busy_vec[9], write_en);
    end
  endtask

  task automatic test_collision();
    clear_inputs();
    issue_valid = 1'b1; issue_rd = 5'd12;
    @(negedge clk); issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    @(negedge clk); alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd12;
    vectors++; if (write_en !== 1'b1 || write_addr !== 5'd12 || busy_vec[12] !== 1'b1) begin
      miscompares++; $display("FAIL collide_setup: got en=%0b addr=%0d busy=%0b expected 1/12/1", write_en, write_addr, busy_vec[12]);
    end
    @(negedge clk); issue_valid = 1'b0;
    vectors++; if (busy_vec[12] !== 1'b1 || write_en !== 1'b0) begin
      miscompares++; $display("FAIL collide_set_wins: got busy=%0b en=%0b expected 1/0", busy_vec[12], write_en);
    end
    @(negedge clk);
    vectors++; if (busy_vec[12] !== 1'b1) begin miscompares++; $display("FAIL collide_hold: got %0b expected 1", busy_vec[12]); end
  endtask

  task automatic test_x0();
    apply_reset();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    vectors++; if (lsu_ready !== 1'b1) begin miscompares++; $display("FAIL x0_ready: got %0b expected 1", lsu_ready); end
    @(negedge clk); clear_inputs();
    vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL x0_we: got %0b expected 0", write_en); end
    vectors++; if (busy_vec !== 32'h0 || idle !== 1'b1) begin miscompares++; $display("FAIL x0_busy_idle: got busy=%h idle=%0b expected 0/1", busy_vec, idle); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h100 + 32'(i);
      @(negedge clk);
      vectors++; if (write_en !== 1'b1 || write_addr !== 5'(i) || write_data !== 32'h100 + 32'(i)) begin
        miscompares++; $display("FAIL b2b[%0d]: got en=%0b addr=%0d data=%h", i, write_en, write_addr, write_data);
      end
    end
    clear_inputs();
    @(negedge clk);
    vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %0b expected 0", write_en); end
  endtask

  // Reference: writes land one cycle after acceptance; the ALU is favoured once it has lost LIMIT contended rounds in a row.
  task automatic test_random();
    logic [31:0] m_busy = '0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_losses = 0;
    bit          alu_pend = 0, lsu_pend = 0;
    bit          alu_win, lsu_win, favour;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      vectors++; if (write_en !== m_we) begin miscompares++; $display("FAIL rand_we[%0d]: got %0b expected %0b", c, write_en, m_we); end
      if (m_we) begin
        vectors++; if (write_addr !== m_addr || write_data !== m_data) begin
          miscompares++; $display("FAIL rand_write[%0d]: got %0d/%h expected %0d/%h", c, write_addr, write_data, m_addr, m_data);
        end
      end
      vectors++; if (busy_vec !== m_busy) begin miscompares++; $display("FAIL rand_busy[%0d]: got %h expected %h", c, busy_vec, m_busy); end
      vectors++; if (idle !== (m_busy == 0 && !m_we)) begin miscompares++; $display("FAIL rand_idle[%0d]: got %0b", c, idle); end

      if (!alu_pend) begin alu_valid = ($urandom_range(0, 3) != 0); alu_rd = 5'($urandom_range(0, 15)); alu_data = $urandom; end
      if (!lsu_pend) begin lsu_valid = ($urandom_range(0, 3) != 0); lsu_rd = 5'($urandom_range(0, 15)); lsu_data = $urandom; end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 15));

      favour  = (m_losses >= LIMIT);
      alu_win = alu_valid && (!lsu_valid || favour);
      lsu_win = lsu_valid && !alu_win;
      #1;
      vectors++; if (alu_ready !== (!lsu_valid || favour) || lsu_ready !== (!alu_valid || !favour)) begin
        miscompares++; $display("FAIL rand_ready[%0d]: got alu=%0b lsu=%0b losses=%0d", c, alu_ready, lsu_ready, m_losses);
      end

      if (m_we) m_busy[m_addr] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (alu_win) m_losses = 0;
      else if (lsu_win && alu_valid && m_losses < LIMIT) m_losses++;
      m_we = 1'b0;
      if (alu_win && alu_rd != 0) begin m_we = 1'b1; m_addr = alu_rd; m_data = alu_data; end
      if (lsu_win && lsu_rd != 0) begin m_we = 1'b1; m_addr = lsu_rd; m_data = lsu_data; end
      alu_pend = alu_valid && !alu_win;
      lsu_pend = lsu_valid && !lsu_win;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_scoreboard_timing();
    test_collision();
    test_x0();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
